// File: rtl/seq_shift_add_mult.sv
`default_nettype none
// ============================================================================
// Module      : seq_shift_add_mult (with companion rca)
// Description : Sequential unsigned N x N shift-add multiplier producing a
//               2N-bit product, one multiplier bit per clock, accumulating
//               partial products through an N-bit ripple-carry adder.
// Revision    : 1.0 - initial release
// ============================================================================

// Ripple-carry adder: sum/cout = a + b + cin
module rca #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);
  logic [N:0] w_carry;

  assign w_carry[0] = cin;

  for (genvar i = 0; i < N; i++) begin : g_fa
    assign sum[i]       = a[i] ^ b[i] ^ w_carry[i];
    assign w_carry[i+1] = (a[i] & b[i]) | (w_carry[i] & (a[i] ^ b[i]));
  end

  assign cout = w_carry[N];
endmodule

module seq_shift_add_mult #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           ready,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [N-1:0]    r_mcand;
  logic [2*N-1:0]  r_p;       // {hi, lo}; lo starts as the multiplier
  logic [CW-1:0]   r_count;
  logic [2*N-1:0]  r_product;

  logic [N-1:0]    w_addend;
  logic [N-1:0]    w_s;
  logic            w_c;
  logic [2*N-1:0]  w_p_shift;
  logic            w_last;

  // Add the multiplicand into the high half only when the current LSB is set
  assign w_addend = r_p[0] ? r_mcand : '0;

  rca #(.N(N)) u_rca (
    .a    (r_p[2*N-1:N]),
    .b    (w_addend),
    .cin  (1'b0),
    .sum  (w_s),
    .cout (w_c)
  );

  // The adder carry becomes the new MSB so no partial-product bit is lost
  assign w_p_shift = {w_c, w_s, r_p[N-1:1]};
  assign w_last    = (r_count == C_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode: IDLE -> RUN on start, RUN for N cycles, DONE for one
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start)  w_next = RUN;
      RUN:     if (w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Datapath: operand capture, shift-add accumulation and result latch
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mcand   <= '0;
      r_p       <= '0;
      r_count   <= '0;
      r_product <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_mcand <= a;
            r_p     <= {{N{1'b0}}, b};
            r_count <= '0;
          end
        end
        RUN: begin
          r_p <= w_p_shift;
          if (w_last) begin
            r_count   <= '0;
            r_product <= w_p_shift;
          end else begin
            r_count <= r_count + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign ready   = (r_state == IDLE);
  assign busy    = (r_state == RUN);
  assign done    = (r_state == DONE);
  assign product = r_product;
endmodule
`default_nettype wire

// File: tb/tb_seq_shift_add_mult.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_shift_add_mult
// Description : Scoreboard bench for seq_shift_add_mult at N=8 and N=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_shift_add_mult;
  typedef struct {
    logic [15:0] p;
    int          c;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start8 = 1'b0, start4 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [3:0]  a4 = '0, b4 = '0;
  logic        ready8, busy8, done8, ready4, busy4, done4;
  logic [15:0] product8;
  logic [7:0]  product4;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q8[$];
  exp_t q4[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_shift_add_mult #(.N(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .ready(ready8), .busy(busy8), .done(done8), .product(product8)
  );

  seq_shift_add_mult #(.N(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
    .ready(ready4), .busy(busy4), .done(done4), .product(product4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor for the N=8 instance
  int          brun8 = 0;
  logic        hold8 = 1'b0;
  logic [15:0] held8 = '0;
  always @(negedge clk) begin
    exp_t e;
    if (hold8) begin
      chk("hold8", {16'h0, product8}, {16'h0, held8});
      hold8 = 1'b0;
    end
    if (!rst_n) brun8 = 0;
    else if (busy8) brun8++;
    if (done8) begin
      if (q8.size() == 0) begin
        chk("unexpected_done8", 32'd1, 32'd0);
      end else begin
        e = q8.pop_front();
        chk("product8", {16'h0, product8}, {16'h0, e.p});
        chk("latency8", cyc, e.c);
        chk("busylen8", brun8, 8);
        hold8 = 1'b1;
        held8 = e.p;
      end
      brun8 = 0;
    end
  end

  // Monitor for the N=4 instance
  int brun4 = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) brun4 = 0;
    else if (busy4) brun4++;
    if (done4) begin
      if (q4.size() == 0) begin
        chk("unexpected_done4", 32'd1, 32'd0);
      end else begin
        e = q4.pop_front();
        chk("product4", {24'h0, product4}, {16'h0, e.p});
        chk("latency4", cyc, e.c);
        chk("busylen4", brun4, 4);
      end
      brun4 = 0;
    end
  end

  // Issue one N=8 operation; optionally register its expected result
  task automatic op8(input logic [7:0] x, input logic [7:0] y, input bit push);
    int guard = 0;
    while (!ready8 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) chk("ready8_timeout", 32'd0, 32'd1);
    start8 = 1'b1; a8 = x; b8 = y;
    @(negedge clk);
    if (push) q8.push_back('{16'(x) * 16'(y), cyc + 8});
    start8 = 1'b0;
  endtask

  task automatic op4(input logic [3:0] x, input logic [3:0] y);
    int guard = 0;
    while (!ready4 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) chk("ready4_timeout", 32'd0, 32'd1);
    start4 = 1'b1; a4 = x; b4 = y;
    @(negedge clk);
    q4.push_back('{16'(x) * 16'(y), cyc + 4});
    start4 = 1'b0;
  endtask

  initial begin
    int k;
    int guard;
    // Reset for two cycles
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'h0, ready8}, 32'd1);
    chk("rst_busy",  {31'h0, busy8},  32'd0);
    chk("rst_done",  {31'h0, done8},  32'd0);
    chk("rst_prod",  {16'h0, product8}, 32'h0);
    chk("rst_ready4", {31'h0, ready4}, 32'd1);
    chk("rst_prod4", {24'h0, product4}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic and carry-heavy operands
    op8(8'd13, 8'd11, 1'b1);    // 0x008F
    op8(8'd255, 8'd255, 1'b1);  // 0xFE01
    op8(8'd0, 8'd200, 1'b1);    // 0x0000
    op8(8'd200, 8'd0, 1'b1);    // 0x0000

    // Start during RUN must be ignored
    op8(8'd3, 8'd5, 1'b1);      // 0x000F
    repeat (2) @(negedge clk);
    start8 = 1'b1; a8 = 8'd7; b8 = 8'd7;
    @(negedge clk);
    start8 = 1'b0;

    // Reset at the 4th RUN edge discards the operation
    op8(8'd200, 8'd100, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_ready", {31'h0, ready8}, 32'd1);
    chk("midrst_busy",  {31'h0, busy8},  32'd0);
    chk("midrst_done",  {31'h0, done8},  32'd0);
    chk("midrst_prod",  {16'h0, product8}, 32'h0);
    repeat (12) @(negedge clk);

    // start held high: back-to-back 6*7 then 9*9, one DONE cycle between
    start8 = 1'b1; a8 = 8'd6; b8 = 8'd7;
    @(negedge clk);
    k = cyc;
    q8.push_back('{16'h002A, k + 8});
    q8.push_back('{16'h0051, k + 18});
    a8 = 8'd9; b8 = 8'd9;
    repeat (10) @(negedge clk);
    start8 = 1'b0;
    repeat (12) @(negedge clk);

    // Exhaustive sweep on the 4-bit instance
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        op4(4'(i), 4'(j));

    // Drain scoreboards with a bound
    guard = 0;
    while ((q8.size() != 0 || q4.size() != 0) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (q8.size() != 0) chk("missing_done8", q8.size(), 32'd0);
    if (q4.size() != 0) chk("missing_done4", q4.size(), 32'd0);
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
